// File: rtl/sine_sweep_ctrl_if.sv
// Bundle between the sweep requester/generator side (master) and the sweep
// controller (slave): request handshake, sweep configuration and generator controls.
interface sine_sweep_ctrl_if #(
   parameter int PHASE_W = 32,
   parameter int DWELL_W = 16
) ();

   logic               start;
   logic               abort;
   logic [PHASE_W-1:0] f_start;
   logic [PHASE_W-1:0] f_stop;
   logic [PHASE_W-1:0] f_step;
   logic [DWELL_W-1:0] dwell;
   logic               cnt_edge;
   logic [PHASE_W-1:0] phase_inc;
   logic               phase_clr;
   logic               gen_en;
   logic               busy;
   logic               done;
   logic [DWELL_W-1:0] step_idx;

   modport master (
      output start, abort, f_start, f_stop, f_step, dwell, cnt_edge,
      input  phase_inc, phase_clr, gen_en, busy, done, step_idx
   );

   modport slave (
      input  start, abort, f_start, f_stop, f_step, dwell, cnt_edge,
      output phase_inc, phase_clr, gen_en, busy, done, step_idx
   );

endinterface

// File: rtl/sine_sweep_ctrl.sv
// Sweep/burst controller: walks the generator's phase-increment word through a
// linear sweep, holding each tone for a programmed number of sine periods.
module sine_sweep_ctrl #(
   parameter int PHASE_W = 32,
   parameter int DWELL_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   sine_sweep_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

   logic [1:0]         state;
   logic [PHASE_W-1:0] f_stop_q;
   logic [PHASE_W-1:0] f_step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] period_cnt;
   logic [PHASE_W-1:0] phase_inc_q;
   logic               phase_clr_q;
   logic               gen_en_q;
   logic               busy_q;
   logic               done_q;
   logic [DWELL_W-1:0] step_idx_q;

   logic [PHASE_W:0]   nxt;
   logic               last_tone;
   logic               dwell_hit;

   // One extra bit so a carry out of the phase word is seen rather than wrapped.
   function automatic logic [PHASE_W:0] next_tone(input logic [PHASE_W-1:0] cur,
                                                  input logic [PHASE_W-1:0] step);
      return {1'b0, cur} + {1'b0, step};
   endfunction

   function automatic logic sweep_end(input logic [PHASE_W:0]   n,
                                      input logic [PHASE_W-1:0] step,
                                      input logic [PHASE_W-1:0] stop);
      return (step == '0) || n[PHASE_W] || (n[PHASE_W-1:0] > stop);
   endfunction

   assign nxt       = next_tone(phase_inc_q, f_step_q);
   assign last_tone = sweep_end(nxt, f_step_q, f_stop_q);
   assign dwell_hit = (period_cnt == dwell_q - ONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         f_stop_q    <= '0;
         f_step_q    <= '0;
         dwell_q     <= '0;
         period_cnt  <= '0;
         phase_inc_q <= '0;
         phase_clr_q <= 1'b0;
         gen_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         step_idx_q  <= '0;
      end else begin
         phase_clr_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  state       <= S_RUN;
                  f_stop_q    <= bus.f_stop;
                  f_step_q    <= bus.f_step;
                  dwell_q     <= (bus.dwell == '0) ? ONE : bus.dwell;
                  period_cnt  <= '0;
                  phase_inc_q <= bus.f_start;
                  phase_clr_q <= 1'b1;
                  gen_en_q    <= 1'b1;
                  busy_q      <= 1'b1;
                  step_idx_q  <= '0;
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  state       <= S_IDLE;
                  gen_en_q    <= 1'b0;
                  phase_inc_q <= '0;
                  busy_q      <= 1'b0;
               end else if (bus.cnt_edge) begin
                  if (dwell_hit) begin
                     state      <= S_STEP;
                     period_cnt <= '0;
                  end else begin
                     period_cnt <= period_cnt + ONE;
                  end
               end
            end
            S_STEP: begin
               // cnt_edge is deliberately ignored here; the next tone's count starts in RUN.
               if (bus.abort) begin
                  state       <= S_IDLE;
                  gen_en_q    <= 1'b0;
                  phase_inc_q <= '0;
                  busy_q      <= 1'b0;
               end else if (last_tone) begin
                  state       <= S_DONE;
                  done_q      <= 1'b1;
                  gen_en_q    <= 1'b0;
                  phase_inc_q <= '0;
                  busy_q      <= 1'b0;
               end else begin
                  state       <= S_RUN;
                  phase_inc_q <= nxt[PHASE_W-1:0];
                  step_idx_q  <= step_idx_q + ONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.phase_inc = phase_inc_q;
   assign bus.phase_clr = phase_clr_q;
   assign bus.gen_en    = gen_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.step_idx  = step_idx_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Bench for sine_sweep_ctrl: vector table, directed corner sequences and random
// traffic against a tone-list reference model.
module tb_sine_sweep_ctrl;

   localparam int PW = 32;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sine_sweep_ctrl_if #(.PHASE_W(PW), .DWELL_W(DW)) bus ();
   sine_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [PW-1:0] phase_inc;
      logic          phase_clr;
      logic          gen_en;
      logic          busy;
      logic          done;
      logic [DW-1:0] step_idx;
   } outs_t;

   typedef struct {
      logic [2:0]    in_bits;   // {start, abort, cnt_edge}
      logic [PW-1:0] phase_inc;
      logic [3:0]    flags;     // {phase_clr, gen_en, busy, done}
      logic [DW-1:0] idx;
   } vec_t;

   // Reference model: the sweep is a precomputed list of tones; each tone needs
   // dwell periods, then one hand-over cycle, then the next tone or the done pulse.
   typedef enum int {M_IDLE, M_TONE, M_SWITCH, M_FIN} mphase_t;
   mphase_t     m_ph;
   logic [63:0] m_tones[$];
   int          m_left;
   int          m_dwell;
   outs_t       exp_o;

   function automatic outs_t dut_outs();
      outs_t o;
      o.phase_inc = bus.phase_inc;
      o.phase_clr = bus.phase_clr;
      o.gen_en    = bus.gen_en;
      o.busy      = bus.busy;
      o.done      = bus.done;
      o.step_idx  = bus.step_idx;
      return o;
   endfunction

   function automatic vec_t mk(input logic [2:0] i, input logic [PW-1:0] p,
                               input logic [3:0] f, input logic [DW-1:0] x);
      vec_t v;
      v.in_bits = i;
      v.phase_inc = p;
      v.flags = f;
      v.idx = x;
      return v;
   endfunction

   task automatic model_reset();
      m_ph = M_IDLE;
      m_tones.delete();
      m_left = 0;
      m_dwell = 1;
      exp_o = '0;
   endtask

   task automatic build_tones(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                              input logic [PW-1:0] st);
      logic [63:0] f;
      logic [63:0] n;
      m_tones.delete();
      f = {32'h0, fs};
      m_tones.push_back(f);
      while (st != '0) begin
         n = f + {32'h0, st};
         if (n > {32'h0, fe} || n > 64'h0000_0000_FFFF_FFFF) break;
         m_tones.push_back(n);
         f = n;
      end
   endtask

   task automatic model_go_idle();
      exp_o.gen_en = 1'b0;
      exp_o.phase_inc = '0;
      exp_o.busy = 1'b0;
      m_ph = M_IDLE;
   endtask

   task automatic model_clock();
      logic [63:0] t;
      if (!reset) begin
         model_reset();
         return;
      end
      exp_o.phase_clr = 1'b0;
      exp_o.done = 1'b0;
      case (m_ph)
         M_IDLE: if (bus.start && !bus.abort) begin
            build_tones(bus.f_start, bus.f_stop, bus.f_step);
            m_dwell = (bus.dwell == '0) ? 1 : int'(bus.dwell);
            m_left = m_dwell;
            t = m_tones.pop_front();
            exp_o.phase_inc = t[PW-1:0];
            exp_o.phase_clr = 1'b1;
            exp_o.gen_en = 1'b1;
            exp_o.busy = 1'b1;
            exp_o.step_idx = '0;
            m_ph = M_TONE;
         end
         M_TONE: begin
            if (bus.abort) model_go_idle();
            else if (bus.cnt_edge) begin
               m_left--;
               if (m_left == 0) m_ph = M_SWITCH;
            end
         end
         M_SWITCH: begin
            if (bus.abort) model_go_idle();
            else if (m_tones.size() == 0) begin
               exp_o.done = 1'b1;
               exp_o.gen_en = 1'b0;
               exp_o.phase_inc = '0;
               exp_o.busy = 1'b0;
               m_ph = M_FIN;
            end else begin
               t = m_tones.pop_front();
               exp_o.phase_inc = t[PW-1:0];
               exp_o.step_idx = exp_o.step_idx + DW'(1);
               m_left = m_dwell;
               m_ph = M_TONE;
            end
         end
         default: m_ph = M_IDLE;
      endcase
   endtask

   task automatic check_out(input string name, input outs_t exp);
      outs_t act;
      act = dut_outs();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got phase_inc=%h clr=%b gen_en=%b busy=%b done=%b idx=%0d, want phase_inc=%h clr=%b gen_en=%b busy=%b done=%b idx=%0d",
                  name, act.phase_inc, act.phase_clr, act.gen_en, act.busy, act.done, act.step_idx,
                  exp.phase_inc, exp.phase_clr, exp.gen_en, exp.busy, exp.done, exp.step_idx);
      end
   endtask

   task automatic check_val(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input bit chk, input string name);
      @(posedge clk);
      model_clock();
      #1;
      if (chk) check_out(name, exp_o);
   endtask

   task automatic drive(input logic s, input logic a, input logic e);
      bus.start = s;
      bus.abort = a;
      bus.cnt_edge = e;
   endtask

   task automatic set_cfg(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                          input logic [PW-1:0] st, input logic [DW-1:0] dw);
      bus.f_start = fs;
      bus.f_stop = fe;
      bus.f_step = st;
      bus.dwell = dw;
   endtask

   task automatic edges(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick(1'b1, name);
         drive(1'b0, 1'b0, 1'b0);
         tick(1'b1, name);
      end
   endtask

   task automatic rand_cfg();
      logic [PW-1:0] base;
      if ($urandom_range(0, 7) == 0) begin
         base = 32'hFFFF_FF00 + $urandom_range(0, 255);
         bus.f_stop = 32'hFFFF_FFFF;
      end else begin
         base = $urandom_range(0, 1000);
         bus.f_stop = ($urandom_range(0, 5) == 0) ? (base >> 1) : base + $urandom_range(0, 300);
      end
      bus.f_start = base;
      bus.f_step = 32'd50 * $urandom_range(0, 4);
      bus.dwell = DW'($urandom_range(0, 3));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[17];
      outs_t zero_o;
      bit seen;
      zero_o = '0;

      tbl[0]  = mk(3'b100, 32'd100, 4'b1110, 8'd0);
      tbl[1]  = mk(3'b000, 32'd100, 4'b0110, 8'd0);
      tbl[2]  = mk(3'b001, 32'd100, 4'b0110, 8'd0);
      tbl[3]  = mk(3'b000, 32'd100, 4'b0110, 8'd0);
      tbl[4]  = mk(3'b001, 32'd100, 4'b0110, 8'd0);
      tbl[5]  = mk(3'b001, 32'd200, 4'b0110, 8'd1);
      tbl[6]  = mk(3'b001, 32'd200, 4'b0110, 8'd1);
      tbl[7]  = mk(3'b000, 32'd200, 4'b0110, 8'd1);
      tbl[8]  = mk(3'b100, 32'd200, 4'b0110, 8'd1);
      tbl[9]  = mk(3'b001, 32'd200, 4'b0110, 8'd1);
      tbl[10] = mk(3'b000, 32'd300, 4'b0110, 8'd2);
      tbl[11] = mk(3'b001, 32'd300, 4'b0110, 8'd2);
      tbl[12] = mk(3'b001, 32'd300, 4'b0110, 8'd2);
      tbl[13] = mk(3'b000, 32'd0,   4'b0001, 8'd2);
      tbl[14] = mk(3'b000, 32'd0,   4'b0000, 8'd2);
      tbl[15] = mk(3'b110, 32'd0,   4'b0000, 8'd2);
      tbl[16] = mk(3'b000, 32'd0,   4'b0000, 8'd2);

      model_reset();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         rand_cfg();
         tick(1'b1, "reset_hold");
      end
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      tick(1'b1, "reset_release");
      tick(1'b1, "reset_idle");

      set_cfg(32'd100, 32'd300, 32'd100, 8'd2);
      for (int i = 0; i < 17; i++) begin
         outs_t e;
         drive(tbl[i].in_bits[2], tbl[i].in_bits[1], tbl[i].in_bits[0]);
         tick(1'b0, "");
         e.phase_inc = tbl[i].phase_inc;
         {e.phase_clr, e.gen_en, e.busy, e.done} = tbl[i].flags;
         e.step_idx = tbl[i].idx;
         check_out($sformatf("tbl[%0d]", i), e);
      end

      set_cfg(32'd500, 32'd200, 32'd100, 8'd0);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "bnd_start");
      check_val("bnd_phase", bus.phase_inc, 32'd500);
      drive(1'b0, 1'b0, 1'b0);
      tick(1'b1, "bnd_wait");
      edges(1, "bnd_edge");
      check_val("bnd_done", 32'(bus.done), 32'd1);
      check_val("bnd_idx", 32'(bus.step_idx), 32'd0);
      tick(1'b1, "bnd_idle");

      set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 8'd1);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "ovf_start");
      check_val("ovf_phase", bus.phase_inc, 32'hFFFF_FF00);
      edges(1, "ovf_edge");
      check_val("ovf_done", 32'(bus.done), 32'd1);
      tick(1'b1, "ovf_idle");

      set_cfg(32'd100, 32'd1000, 32'd0, 8'd3);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "zstep_start");
      edges(2, "zstep_edge");
      check_val("zstep_busy", 32'(bus.busy), 32'd1);
      edges(1, "zstep_edge");
      check_val("zstep_done", 32'(bus.done), 32'd1);
      tick(1'b1, "zstep_idle");

      set_cfg(32'd100, 32'd300, 32'd100, 8'd2);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "abort_start");
      edges(2, "abort_edge");
      check_val("abort_tone1", bus.phase_inc, 32'd200);
      check_val("abort_idx1", 32'(bus.step_idx), 32'd1);
      drive(1'b0, 1'b1, 1'b0);
      tick(1'b1, "abort_cycle");
      check_val("abort_gen_en", 32'(bus.gen_en), 32'd0);
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, "abort_after");
      drive(1'b1, 1'b1, 1'b0);
      tick(1'b1, "abort_start_both");
      check_val("both_busy", 32'(bus.busy), 32'd0);
      drive(1'b0, 1'b0, 1'b0);
      tick(1'b1, "both_idle");

      set_cfg(32'd100, 32'd300, 32'd100, 8'd2);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "arst_start");
      edges(1, "arst_edge");
      #2;
      reset = 1'b0;
      #1;
      check_out("arst_immediate", zero_o);
      model_reset();
      tick(1'b1, "arst_hold");
      reset = 1'b1;
      tick(1'b1, "arst_release");

      set_cfg(32'd0, 32'd300, 32'd1, 8'd1);
      drive(1'b1, 1'b0, 1'b0);
      tick(1'b1, "wrap_start");
      drive(1'b0, 1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         tick(1'b1, "wrap_run");
         seen = bus.done;
      end
      check_val("wrap_done_seen", 32'(seen), 32'd1);
      check_val("wrap_idx", 32'(bus.step_idx), 32'd44);
      drive(1'b0, 1'b0, 1'b0);
      tick(1'b1, "wrap_idle");

      for (int i = 0; i < 3000; i++) begin
         rand_cfg();
         drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0));
         reset = ($urandom_range(0, 399) != 0);
         tick(1'b1, "rand");
      end
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sine_sweep_ctrl.md
Name: sine_sweep_ctrl

Overview:
Sweep/burst controller for the sinewave generator. It sequences the generator's phase-increment (frequency) word through a linear frequency sweep. It holds each step for a programmed number of completed sine periods, counted from the generator's cnt_edge wrap pulse. It sits between the configuration/CPU side and the sinewave datapath, with a start/busy/done handshake toward the requester.

Parameters:
PHASE_W, 32, width of frequency/phase-increment words (matches generator cnt)
DWELL_W, 16, width of dwell (periods per step) and step index

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  sweep request, sampled in IDLE only
abort  in  1  terminate sweep immediately
f_start  in  PHASE_W  first phase-increment word
f_stop  in  PHASE_W  upper bound of phase-increment word (inclusive)
f_step  in  PHASE_W  increment added per step
dwell  in  DWELL_W  sine periods per step; 0 treated as 1
cnt_edge  in  1  one-cycle pulse per completed sine period from the generator
phase_inc  out  PHASE_W  frequency word driven to the generator
phase_clr  out  1  one-cycle pulse: generator clears its phase accumulator
gen_en  out  1  generator enable
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on normal sweep completion
step_idx  out  DWELL_W  index of the current step, 0-based

Behaviour:
- Reset (reset=0, async): state=IDLE. phase_inc=0, phase_clr=0, gen_en=0, busy=0, done=0, step_idx=0. Internal period counter=0 and latched config=0.
- All outputs are registered.
- States:
  - IDLE, RUN, STEP, DONE.
  - The encoding is free, but the state must be observable via busy, done and gen_en.
- IDLE:
  - gen_en=0, phase_inc=0, busy=0.
  - On start=1 and abort=0, latch f_start, f_stop, f_step and dwell, with dwell 0 stored as 1.
  - Next cycle: state=RUN, phase_inc=f_start, phase_clr=1 (this cycle only), gen_en=1, busy=1, step_idx=0, period counter=0.
  - Start-to-gen_en latency is 1 cycle.
- RUN:
  - Each cnt_edge=1 increments the period counter.
  - When cnt_edge=1 and counter==dwell-1, go to STEP next cycle and clear the counter.
  - Config inputs changing during RUN have no effect; only latched values are used.
- STEP, one cycle, gen_en stays 1:
  - Compute nxt = phase_inc + f_step in PHASE_W+1 bits.
  - If f_step==0, nxt > f_stop, or nxt overflows PHASE_W, go to DONE.
  - Otherwise phase_inc<=nxt and step_idx<=step_idx+1, then back to RUN.
  - No phase_clr at a step: phase stays continuous.
  - A cnt_edge arriving in the STEP cycle is discarded; counting restarts in RUN.
- DONE, one cycle:
  - done=1, gen_en=0, phase_inc=0, busy=0, then IDLE.
  - start is not accepted in DONE.
- f_start > f_stop: one dwell at f_start, then DONE. The first tone is always played.
- f_step wrapping step_idx: step_idx wraps modulo 2^DWELL_W; this does not terminate the sweep.
- abort=1 in RUN or STEP: next cycle IDLE, gen_en=0, phase_inc=0, busy=0, done stays 0.
- abort in DONE: DONE completes normally (done=1).
- abort and start both high in IDLE: abort wins and start is ignored.
- start while busy=1 is ignored; no queuing.
- Reset asserted mid-sweep: all outputs go to their reset values immediately (asynchronous), with no done pulse.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0; release -> still IDLE, outputs 0.
- Basic sweep: f_start=100, f_stop=300, f_step=100, dwell=2, pulse start, cnt_edge every 10 cycles ->
  - 1 cycle after start: phase_inc=100, phase_clr pulses once.
  - After 2 edges: STEP, then phase_inc=200 (step_idx=1); later 300 (step_idx=2).
  - After 6 total edges: done pulses once, gen_en=0, phase_inc=0.
- Boundary: f_start=500, f_stop=200, dwell=0 -> a single edge ends the sweep. phase_inc=500 until done; step_idx stays 0.
- Overflow/zero step:
  - f_start=32'hFFFF_FF00, f_step=32'h200, f_stop=32'hFFFF_FFFF -> DONE after the first dwell, phase_inc never wraps.
  - f_step=0 -> DONE after the first dwell.
- Abort: abort during RUN at step 1 of the basic sweep -> next cycle busy=0, gen_en=0, phase_inc=0, done never asserted. Abort and start together in IDLE -> stays IDLE.
- Ignored events:
  - start pulsed during RUN -> no phase_clr, sweep unaffected.
  - cnt_edge coincident with the STEP cycle -> not counted; each step still requires dwell edges in RUN.
  - Reset mid-sweep -> immediate return to reset values.
